// File: rtl/arith_pkg.sv
// Shared wide-arithmetic definitions: controller states, default operand geometry and a
// width helper used to size chunk counters.
package arith_pkg;

  typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

  localparam int unsigned DefaultW      = 32;
  localparam int unsigned DefaultMaxBit = 128;

  // Bits needed to count 0..n-1, never less than one.
  function automatic int unsigned clog2_min1(int unsigned n);
    int unsigned r;
    int unsigned v;
    r = 0;
    v = 1;
    while (v < n) begin
      v = v * 2;
      r = r + 1;
    end
    return (r == 0) ? 1 : r;
  endfunction

endpackage

// File: rtl/chunk_sub.sv
// Combinational W-bit subtractor slice: {bo, d} = x - y - bi, plus a chunk equality flag.
module chunk_sub #(
  parameter int unsigned W = 32
) (
  input  logic [W-1:0] x,
  input  logic [W-1:0] y,
  input  logic         bi,
  output logic [W-1:0] d,
  output logic         bo,
  output logic         eqc
);

  logic [W:0] full;

  always_comb begin
    full = {1'b0, x} - {1'b0, y} - {{W{1'b0}}, bi};
    d    = full[W-1:0];
    bo   = full[W];
    eqc  = (x == y);
  end

endmodule

// File: rtl/serial_block_subtractor.sv
// Multi-cycle wide subtractor: diff = a - b - bin, one W-bit chunk per clock, LSB chunk first.
// Define SUB_OVERFLOW_EN to add the registered signed-overflow output ovf.
module serial_block_subtractor
  import arith_pkg::*;
#(
  parameter int unsigned W      = DefaultW,
  parameter int unsigned MaxBit = DefaultMaxBit
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [MaxBit-1:0] a,
  input  logic [MaxBit-1:0] b,
  input  logic              bin,
  output logic              busy,
  output logic              done,
  output logic [MaxBit-1:0] diff,
  output logic              bout,
`ifdef SUB_OVERFLOW_EN
  output logic              eq,
  output logic              ovf
`else
  output logic              eq
`endif
);

  localparam int unsigned N    = MaxBit / W;
  localparam int unsigned CntW = clog2_min1(N);
  localparam logic [CntW-1:0] LastCnt = CntW'(N - 1);

  state_e                state_q, state_d;
  logic [CntW-1:0]       cnt_q, cnt_d;
  logic [N-1:0][W-1:0]   a_q, a_d;
  logic [N-1:0][W-1:0]   b_q, b_d;
  logic [N-1:0][W-1:0]   diff_q, diff_d;
  logic                  borrow_q, borrow_d;
  logic                  eq_acc_q, eq_acc_d;
  logic                  bout_q, bout_d;
  logic                  eq_q, eq_d;
`ifdef SUB_OVERFLOW_EN
  logic                  ovf_q, ovf_d;
`endif

  logic [W-1:0] chunk_d;
  logic         chunk_bo;
  logic         chunk_eq;

  // Single shared slice; operands are muxed in by the chunk counter.
  chunk_sub #(
    .W (W)
  ) u_chunk_sub (
    .x   (a_q[cnt_q]),
    .y   (b_q[cnt_q]),
    .bi  (borrow_q),
    .d   (chunk_d),
    .bo  (chunk_bo),
    .eqc (chunk_eq)
  );

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    a_d      = a_q;
    b_d      = b_q;
    diff_d   = diff_q;
    borrow_d = borrow_q;
    eq_acc_d = eq_acc_q;
    bout_d   = bout_q;
    eq_d     = eq_q;
`ifdef SUB_OVERFLOW_EN
    ovf_d    = ovf_q;
`endif
    unique case (state_q)
      StIdle: begin
        if (start) begin
          a_d      = a;
          b_d      = b;
          borrow_d = bin;
          eq_acc_d = 1'b1;
          cnt_d    = '0;
          state_d  = StRun;
        end
      end
      StRun: begin
        diff_d[cnt_q] = chunk_d;
        borrow_d      = chunk_bo;
        eq_acc_d      = eq_acc_q & chunk_eq;
        cnt_d         = cnt_q + 1'b1;
        if (cnt_q == LastCnt) begin
          bout_d  = chunk_bo;
          eq_d    = eq_acc_q & chunk_eq;
`ifdef SUB_OVERFLOW_EN
          // chunk_d[W-1] is the result MSB on the last chunk.
          ovf_d   = (a_q[N-1][W-1] != b_q[N-1][W-1]) && (chunk_d[W-1] != a_q[N-1][W-1]);
`endif
          state_d = StDone;
        end
      end
      StDone: state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= StIdle;
      cnt_q    <= '0;
      a_q      <= '0;
      b_q      <= '0;
      diff_q   <= '0;
      borrow_q <= 1'b0;
      eq_acc_q <= 1'b0;
      bout_q   <= 1'b0;
      eq_q     <= 1'b0;
`ifdef SUB_OVERFLOW_EN
      ovf_q    <= 1'b0;
`endif
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      a_q      <= a_d;
      b_q      <= b_d;
      diff_q   <= diff_d;
      borrow_q <= borrow_d;
      eq_acc_q <= eq_acc_d;
      bout_q   <= bout_d;
      eq_q     <= eq_d;
`ifdef SUB_OVERFLOW_EN
      ovf_q    <= ovf_d;
`endif
    end
  end

  assign busy = (state_q != StIdle);
  assign done = (state_q == StDone);
  assign diff = diff_q;
  assign bout = bout_q;
  assign eq   = eq_q;
`ifdef SUB_OVERFLOW_EN
  assign ovf  = ovf_q;
`endif

endmodule

// File: tb/tb_serial_block_subtractor.sv
// Self-checking bench for serial_block_subtractor against an arithmetic reference model.
module tb_serial_block_subtractor;

  localparam int unsigned W      = 32;
  localparam int unsigned MaxBit = 128;
  localparam int unsigned N      = MaxBit / W;

  logic              clk;
  logic              rst_n;
  logic              start;
  logic [MaxBit-1:0] a_in;
  logic [MaxBit-1:0] b_in;
  logic              bin_in;
  logic              busy;
  logic              done;
  logic [MaxBit-1:0] diff;
  logic              bout;
  logic              eq;
`ifdef SUB_OVERFLOW_EN
  logic              ovf;
`endif

  int n_pass;
  int n_total;

  serial_block_subtractor #(
    .W      (W),
    .MaxBit (MaxBit)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .start (start),
    .a     (a_in),
    .b     (b_in),
    .bin   (bin_in),
    .busy  (busy),
    .done  (done),
    .diff  (diff),
    .bout  (bout),
`ifdef SUB_OVERFLOW_EN
    .eq    (eq),
    .ovf   (ovf)
`else
    .eq    (eq)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference: full-precision unsigned subtraction; bit MaxBit is the borrow.
  function automatic logic [MaxBit:0] ref_sub(logic [MaxBit-1:0] x, logic [MaxBit-1:0] y,
                                               logic bi);
    return {1'b0, x} - {1'b0, y} - (MaxBit + 1)'(bi);
  endfunction

  function automatic logic [MaxBit-1:0] rand_wide();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  // Issues one request and waits (bounded) for done; lat counts edges after the accept edge.
  task automatic run_op(input logic [MaxBit-1:0] x, input logic [MaxBit-1:0] y,
                        input logic bi, output int lat, output logic acc);
    @(posedge clk); #1;
    start  = 1'b1;
    a_in   = x;
    b_in   = y;
    bin_in = bi;
    @(posedge clk); #1;
    start  = 1'b0;
    acc    = busy;
    // Scramble inputs to prove operands were latched.
    a_in   = rand_wide();
    b_in   = rand_wide();
    bin_in = ~bi;
    lat    = 0;
    while (lat < 20) begin
      @(posedge clk); #1;
      lat++;
      if (done) break;
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0; start = 1'b0; a_in = '0; b_in = '0; bin_in = 1'b0;
    #12;
    n_total++;
    if ({busy, done, bout, eq, diff} !== '0)
      $display("FAIL reset_outputs: got busy=%b done=%b bout=%b eq=%b diff=%h, want all 0",
               busy, done, bout, eq, diff);
    else n_pass++;
`ifdef SUB_OVERFLOW_EN
    n_total++;
    if (ovf !== 1'b0) $display("FAIL reset_ovf: got %b want 0", ovf);
    else n_pass++;
`endif
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_directed();
    logic [MaxBit-1:0] va [6];
    logic [MaxBit-1:0] vb [6];
    logic              vi [6];
    logic [MaxBit:0]   exp;
    logic [MaxBit-1:0] held;
    int                lat;
    logic              acc;
    va[0] = 128'd5;        vb[0] = 128'd3;        vi[0] = 1'b0;
    va[1] = 128'd0;        vb[1] = 128'd1;        vi[1] = 1'b0;
    va[2] = 128'd1 << 32;  vb[2] = 128'd1;        vi[2] = 1'b0;
    va[3] = {4{32'hDEADBEEF}}; vb[3] = {4{32'hDEADBEEF}}; vi[3] = 1'b1;
    va[4] = {4{32'hDEADBEEF}}; vb[4] = {4{32'hDEADBEEF}}; vi[4] = 1'b0;
    va[5] = 128'd0;        vb[5] = 128'd0;        vi[5] = 1'b1;
    for (int i = 0; i < 6; i++) begin
      run_op(va[i], vb[i], vi[i], lat, acc);
      exp = ref_sub(va[i], vb[i], vi[i]);
      n_total++;
      if (acc !== 1'b1) $display("FAIL dir%0d_busy: got %b want 1", i, acc);
      else n_pass++;
      n_total++;
      if (lat != N) $display("FAIL dir%0d_latency: got %0d want %0d", i, lat, N);
      else n_pass++;
      n_total++;
      if ({bout, diff} !== exp)
        $display("FAIL dir%0d_result: got bout=%b diff=%h want bout=%b diff=%h",
                 i, bout, diff, exp[MaxBit], exp[MaxBit-1:0]);
      else n_pass++;
      n_total++;
      if (eq !== (va[i] == vb[i])) $display("FAIL dir%0d_eq: got %b want %b", i, eq, va[i] == vb[i]);
      else n_pass++;
      held = diff;
      @(posedge clk); #1;
      n_total++;
      if (done !== 1'b0 || busy !== 1'b0 || diff !== held)
        $display("FAIL dir%0d_after_done: got done=%b busy=%b diff=%h want 0 0 %h",
                 i, done, busy, diff, held);
      else n_pass++;
    end
  endtask

  task automatic test_random();
    logic [MaxBit-1:0] x, y;
    logic              bi;
    logic [MaxBit:0]   exp;
    int                lat;
    logic              acc;
    for (int i = 0; i < 40; i++) begin
      x  = rand_wide();
      y  = ($urandom_range(0, 3) == 0) ? x : rand_wide();
      bi = 1'($urandom);
      run_op(x, y, bi, lat, acc);
      exp = ref_sub(x, y, bi);
      n_total++;
      if (lat != N || {bout, diff} !== exp || eq !== (x == y))
        $display("FAIL rand%0d: got lat=%0d bout=%b eq=%b diff=%h want lat=%0d bout=%b eq=%b diff=%h",
                 i, lat, bout, eq, diff, N, exp[MaxBit], x == y, exp[MaxBit-1:0]);
      else n_pass++;
`ifdef SUB_OVERFLOW_EN
      n_total++;
      if (ovf !== ((x[MaxBit-1] != y[MaxBit-1]) && (exp[MaxBit-1] != x[MaxBit-1])))
        $display("FAIL rand%0d_ovf: got %b", i, ovf);
      else n_pass++;
`endif
    end
  endtask

  task automatic test_start_held();
    int               done_at [$];
    logic [MaxBit:0]  exp;
    exp = ref_sub(128'd7, 128'd2, 1'b0);
    @(posedge clk); #1;
    start = 1'b1; a_in = 128'd7; b_in = 128'd2; bin_in = 1'b0;
    for (int c = 0; c < 30; c++) begin
      @(posedge clk); #1;
      if (done) done_at.push_back(c);
    end
    start = 1'b0;
    n_total++;
    if (done_at.size() < 3) $display("FAIL held_pulses: got %0d want >=3", done_at.size());
    else n_pass++;
    for (int i = 1; i < done_at.size(); i++) begin
      n_total++;
      if (done_at[i] - done_at[i-1] != N + 2)
        $display("FAIL held_spacing%0d: got %0d want %0d", i, done_at[i] - done_at[i-1], N + 2);
      else n_pass++;
    end
    n_total++;
    if ({bout, diff} !== exp) $display("FAIL held_result: got %h want %h", diff, exp[MaxBit-1:0]);
    else n_pass++;
    repeat (N + 2) @(posedge clk);
    #1;
  endtask

  task automatic test_ignored_pulse();
    logic [MaxBit-1:0] x, y;
    logic [MaxBit:0]   exp;
    int                lat;
    x = rand_wide(); y = rand_wide();
    exp = ref_sub(x, y, 1'b1);
    @(posedge clk); #1;
    start = 1'b1; a_in = x; b_in = y; bin_in = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    @(posedge clk); #1;
    start = 1'b1; a_in = ~x; b_in = x; bin_in = 1'b0;
    lat = 1;
    @(posedge clk); #1;
    start = 1'b0;
    lat++;
    while (!done && lat < 20) begin
      @(posedge clk); #1;
      lat++;
    end
    n_total++;
    if (lat != N || {bout, diff} !== exp)
      $display("FAIL pulse_in_run: got lat=%0d bout=%b diff=%h want lat=%0d bout=%b diff=%h",
               lat, bout, diff, N, exp[MaxBit], exp[MaxBit-1:0]);
    else n_pass++;
    @(posedge clk); #1;
    n_total++;
    if (busy !== 1'b0) $display("FAIL pulse_no_restart: got busy=%b want 0", busy);
    else n_pass++;
  endtask

  task automatic test_reset_midop();
    logic [MaxBit:0] exp;
    int              lat;
    logic            acc;
    logic            seen;
    @(posedge clk); #1;
    start = 1'b1; a_in = rand_wide() | 128'h1; b_in = '0; bin_in = 1'b0;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    n_total++;
    if ({busy, done, bout, eq, diff} !== '0)
      $display("FAIL midop_reset: got busy=%b done=%b bout=%b eq=%b diff=%h, want all 0",
               busy, done, bout, eq, diff);
    else n_pass++;
    @(negedge clk);
    rst_n = 1'b1;
    seen = 1'b0;
    repeat (N + 3) begin
      @(posedge clk); #1;
      if (done || busy) seen = 1'b1;
    end
    n_total++;
    if (seen !== 1'b0) $display("FAIL midop_no_done: got activity=%b want 0", seen);
    else n_pass++;
    exp = ref_sub(128'd100, 128'd42, 1'b1);
    run_op(128'd100, 128'd42, 1'b1, lat, acc);
    n_total++;
    if (lat != N || {bout, diff} !== exp)
      $display("FAIL midop_recover: got lat=%0d diff=%h want lat=%0d diff=%h",
               lat, diff, N, exp[MaxBit-1:0]);
    else n_pass++;
  endtask

`ifdef SUB_OVERFLOW_EN
  task automatic test_overflow();
    int   lat;
    logic acc;
    run_op(128'd1 << 127, 128'd1, 1'b0, lat, acc);
    n_total++;
    if (ovf !== 1'b1) $display("FAIL ovf_min_minus_one: got %b want 1", ovf);
    else n_pass++;
    run_op(128'd5, 128'd3, 1'b0, lat, acc);
    n_total++;
    if (ovf !== 1'b0) $display("FAIL ovf_small: got %b want 0", ovf);
    else n_pass++;
  endtask
`endif

  initial begin
    n_pass  = 0;
    n_total = 0;
    test_reset();
    test_directed();
    test_random();
    test_start_held();
    test_ignored_pulse();
    test_reset_midop();
`ifdef SUB_OVERFLOW_EN
    test_overflow();
`endif
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
